// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension unit.
//   mode_t  : 3-bit extension mode code carried with each input beat
//   MODE_*  : encodings of the five defined modes (5..7 are reserved)
//   state_t : occupancy of the output skid buffer (EMPTY / ONE / FULL)
package imm_ext_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_SEXT  = 3'd0;
  localparam mode_t MODE_ZEXT  = 3'd1;
  localparam mode_t MODE_UPPER = 3'd2;
  localparam mode_t MODE_BOFF  = 3'd3;
  localparam mode_t MODE_BTGT  = 3'd4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender.
//   imm  [IN_W]  : raw immediate
//   mode [3]     : extension mode (mode_t)
//   pc4  [OUT_W] : PC+4, only consumed by the branch-target mode
//   data [OUT_W] : extended operand (0 for reserved modes)
//   err  [1]     : set when mode is reserved
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  mode_t            mode,
  input  logic [OUT_W-1:0] pc4,
  output logic [OUT_W-1:0] data,
  output logic             err
);

  // Branch modes shift the sign-extended value left by two, so at least
  // two bits of headroom above the immediate are required.
  if (OUT_W < IN_W + 2) begin : g_width_chk
    $error("imm_ext_core: OUT_W must be at least IN_W+2");
  end

  logic signed [OUT_W-1:0] sext;
  logic signed [OUT_W-1:0] boff;
  logic        [OUT_W-1:0] btgt;

  assign sext = signed'({{(OUT_W-IN_W){imm[IN_W-1]}}, imm});
  assign boff = sext <<< 2;
  // Wraps modulo 2^OUT_W; branch targets never flag overflow.
  assign btgt = pc4 + unsigned'(boff);

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (mode)
      MODE_SEXT:  data = unsigned'(sext);
      MODE_ZEXT:  data = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_UPPER: data = {imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BOFF:  data = unsigned'(boff);
      MODE_BTGT:  data = btgt;
      default:    err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit with a registered valid/ready output
// stage backed by a 2-entry skid buffer.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake; in_ready is a pure register output
//   in_imm [IN_W]     : raw immediate
//   in_mode [3]       : extension mode
//   in_pc4 [OUT_W]    : PC+4 for branch-target mode
//   out_valid/out_ready : output handshake
//   out_data [OUT_W]  : extended result (held stable under backpressure)
//   out_err           : beat carried a reserved mode
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  input  logic [OUT_W-1:0] in_pc4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  state_t           state;
  state_t           state_d;
  logic             rdy_q;
  logic             accept;
  logic             consume;
  logic             load_main;
  logic             load_skid;
  logic             skid_to_main;
  logic             vld_p0;
  logic             vld_p1;

  logic [OUT_W-1:0] core_data;
  logic             core_err;
  logic [OUT_W-1:0] data_p0;
  logic             err_p0;
  logic [OUT_W-1:0] data_p1;
  logic             err_p1;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (mode_t'(in_mode)),
    .pc4  (in_pc4),
    .data (core_data),
    .err  (core_err)
  );

  // Main register holds the head of the FIFO; skid holds the second entry.
  assign vld_p0  = (state != EMPTY);
  assign vld_p1  = (state == FULL);
  assign accept  = in_valid && rdy_q;
  assign consume = vld_p0 && out_ready;

  always_comb begin
    state_d      = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && !consume) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (consume && !accept) begin
          state_d   = EMPTY;
        end else if (accept && consume) begin
          load_main = 1'b1;
        end
      end
      FULL: begin
        // rdy_q is low here, so only the drain path exists.
        if (consume) begin
          state_d      = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is registered from the next state so out_ready never reaches
  // it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= state_d;
      rdy_q <= (state_d != FULL);
    end
  end

  // ---- stage p0: main output register (cleared so idle outputs read 0) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0 <= '0;
      err_p0  <= 1'b0;
    end else if (load_main) begin
      data_p0 <= core_data;
      err_p0  <= core_err;
    end else if (skid_to_main) begin
      data_p0 <= data_p1;
      err_p0  <= err_p1;
    end
  end

  // ---- stage p1: skid register, only meaningful while vld_p1 ----
  always_ff @(posedge clk) begin
    if (load_skid) begin
      data_p1 <= core_data;
      err_p1  <= core_err;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_err   = err_p0;

  // vld_p1 documents skid occupancy; tie it into nothing else on purpose.
  logic unused_vld_p1;
  assign unused_vld_p1 = vld_p1;

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic [31:0] in_pc4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  logic        p_in_valid;
  logic        p_in_ready;
  logic [11:0] p_in_imm;
  logic [2:0]  p_in_mode;
  logic [15:0] p_in_pc4;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [15:0] p_out_data;
  logic        p_out_err;

  logic [32:0] sb[$];
  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;

  always #5 clk = ~clk;

  imm_ext_pipe u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_pc4    (in_pc4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(16)) u_dut_p (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (p_in_valid),
    .in_ready  (p_in_ready),
    .in_imm    (p_in_imm),
    .in_mode   (p_in_mode),
    .in_pc4    (p_in_pc4),
    .out_valid (p_out_valid),
    .out_ready (p_out_ready),
    .out_data  (p_out_data),
    .out_err   (p_out_err)
  );

  // Reference model for the default 16->32 configuration: {err, data}.
  function automatic logic [32:0] model(input logic [15:0] imm, input logic [2:0] mode,
                                        input logic [31:0] pc4);
    logic [31:0] s;
    logic [31:0] sh;
    s  = {{16{imm[15]}}, imm};
    sh = {s[29:0], 2'b00};
    case (mode)
      3'd0:    return {1'b0, s};
      3'd1:    return {1'b0, 16'h0000, imm};
      3'd2:    return {1'b0, imm, 16'h0000};
      3'd3:    return {1'b0, sh};
      3'd4:    return {1'b0, pc4 + sh};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge (pop on consume, push on accept),
  // then return 1 time unit after the rising edge for the next drive.
  task automatic tick();
    logic [32:0] exp;
    @(negedge clk);
    if (out_valid && out_ready) begin
      check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("sb_out", {31'd0, out_err, out_data}, {31'd0, exp});
      end
    end
    if (in_valid && in_ready && !rst) begin
      sb.push_back(model(in_imm, in_mode, in_pc4));
      n_acc++;
    end
    check("inflight_le2", {63'd0, sb.size() <= 2}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [15:0] imm, input logic [2:0] mode,
                          input logic [31:0] pc4, input logic [32:0] exp);
    in_valid  = 1'b1;
    in_imm    = imm;
    in_mode   = mode;
    in_pc4    = pc4;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
    check(tag, {31'd0, out_err, out_data}, {31'd0, exp});
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_pc4 = '0; out_ready = 1'b0;
    p_in_valid = 1'b0; p_in_imm = '0; p_in_mode = '0; p_in_pc4 = '0; p_out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_err", {63'd0, out_err}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Parametric instance, IN_W=12 OUT_W=16
    p_in_valid = 1'b1; p_in_imm = 12'h800; p_in_mode = 3'd0;
    @(posedge clk); #1;
    check("p_sext_vld", {63'd0, p_out_valid}, 64'd1);
    check("p_sext", {47'd0, p_out_err, p_out_data}, {47'd0, 1'b0, 16'hF800});
    p_in_mode = 3'd2;
    @(posedge clk); #1;
    check("p_upper", {47'd0, p_out_err, p_out_data}, {47'd0, 1'b0, 16'h8000});
    p_in_valid = 1'b0;

    // Modes, default widths
    directed("sext",  16'h8001, 3'd0, 32'h0, {1'b0, 32'hFFFF8001});
    directed("zext",  16'h8001, 3'd1, 32'h0, {1'b0, 32'h00008001});
    directed("upper", 16'h8001, 3'd2, 32'h0, {1'b0, 32'h80010000});
    directed("boff",  16'h8001, 3'd3, 32'h0, {1'b0, 32'hFFFE0004});
    directed("btgt_neg",  16'hFFFC, 3'd4, 32'h00000010, {1'b0, 32'h00000000});
    directed("btgt_wrap", 16'h0008, 3'd4, 32'hFFFFFFF0, {1'b0, 32'h00000010});
    directed("rsv5", 16'h1234, 3'd5, 32'h0, {1'b1, 32'h0});
    directed("rsv6", 16'h1234, 3'd6, 32'h0, {1'b1, 32'h0});
    directed("rsv7", 16'h1234, 3'd7, 32'h0, {1'b1, 32'h0});
    directed("after_rsv", 16'h1234, 3'd0, 32'h0, {1'b0, 32'h00001234});

    // Backpressure: A then B fill the buffer
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0011; in_mode = 3'd0; in_pc4 = '0;
    tick();
    in_imm = 16'h0022; in_mode = 3'd1;
    tick();
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    check("bp_head_A", {32'd0, out_data}, 64'h11);
    in_imm = 16'h0033; in_mode = 3'd0;
    tick();
    check("bp_hold_A", {31'd0, out_err, out_data}, 64'h11);
    check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_head_B", {31'd0, out_err, out_data}, 64'h22);
    check("bp_ready_back", {63'd0, in_ready}, 64'd1);
    tick();
    check("bp_drained", {63'd0, out_valid}, 64'd0);

    // Continuous traffic
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_imm = 16'($urandom); in_mode = 3'($urandom_range(0, 7));
      in_pc4 = $urandom;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("cont_drained", {32'd0, 32'(sb.size())}, 64'd0);

    // Random streaming, 100 beats, random backpressure
    n_acc = 0;
    for (int c = 0; c < 3000 && n_acc < 100; c++) begin
      in_valid = ($urandom_range(0, 3) != 0); in_imm = 16'($urandom);
      in_mode = 3'($urandom_range(0, 7)); in_pc4 = $urandom;
      out_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    check("stream_count", {32'd0, 32'(n_acc)}, 64'd100);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) tick();
    check("stream_drained", {32'd0, 32'(sb.size())}, 64'd0);

    // Reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0101; in_mode = 3'd0;
    tick();
    in_imm = 16'h0202;
    tick();
    check("rstm_full", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("rstm_out_valid", {63'd0, out_valid}, 64'd0);
    check("rstm_out_data", {32'd0, out_data}, 64'd0);
    check("rstm_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstm_no_emit", {63'd0, out_valid}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate-extension unit for the MIPS datapath. It is the successor to the fixed 16→32 sign extender. It accepts an IN_W-bit immediate plus a mode code and produces an OUT_W-bit operand in one of five modes: sign, zero, upper/LUI, branch offset, or branch target. Results pass through a registered valid/ready stage with a 2-entry skid buffer, so the unit sits between decode and execute without breaking the ready path.

## Interface
Parameters:
- IN_W, 16, immediate width.
- OUT_W, 32, result width; legal only if OUT_W ≥ IN_W+2 (elaboration-time check).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  3  extension mode.
- in_pc4  in  OUT_W  PC+4; used only by mode 4.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  extended result.
- out_err  out  1  beat carried a reserved mode.

## Operation
- Modes (S = in_imm sign-extended to OUT_W):
  - 0 SEXT: S.
  - 1 ZEXT: in_imm zero-extended.
  - 2 UPPER: in_imm in bits [OUT_W-1:OUT_W-IN_W], zeros below.
  - 3 BOFF: S<<2, truncated to OUT_W.
  - 4 BTGT: in_pc4 + (S<<2), modulo 2^OUT_W; no overflow flag.
  - 5–7: reserved. out_data = 0, out_err = 1.
- out_err = 0 for modes 0–4.
- Result is computed combinationally from the input beat and captured on acceptance (in_valid && in_ready).
- Storage: a main output register, plus one skid register.
  - A beat accepted while the main register holds data that is not being consumed goes into the skid register.
- States: EMPTY (0 held), ONE (main valid), FULL (main + skid valid).
  - EMPTY: accept → ONE.
  - ONE: accept & !consume → FULL; consume & !accept → EMPTY; both → ONE (new beat replaces main); neither → ONE.
  - FULL: consume → ONE (skid moves to main); no accept possible.
- in_ready = (state != FULL), driven from a register, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_data/out_err come from the main register and stay stable while out_valid && !out_ready.
- Ordering is strictly FIFO. No beat is dropped or duplicated.

## Timing
- Reset (sync, rst=1 at edge): state EMPTY. out_valid=0, out_data=0, out_err=0, in_ready=1 from the cycle after the reset edge.
- While rst is high, in_ready=1 is a don't-care for the source; no beat is accepted.
- Reset mid-operation discards main and skid contents; the next cycle shows out_valid=0.
- Latency: a beat accepted at edge N appears on out_data after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure: if out_ready drops, one further beat is absorbed (FULL). in_ready falls in the cycle after entering FULL.
- Simultaneous accept and consume in ONE holds the occupancy at one entry.
- in_imm, in_mode and in_pc4 are sampled only at acceptance. Values in non-accepted cycles are ignored.

## Structure
- Shared package imm_ext_pkg holds:
  - mode encodings: MODE_SEXT=0, MODE_ZEXT=1, MODE_UPPER=2, MODE_BOFF=3, MODE_BTGT=4;
  - the 3-bit mode typedef;
  - state encodings EMPTY/ONE/FULL.
- One natural sub-module: imm_ext_core. It is purely combinational: {in_imm, in_mode, in_pc4} → {data, err}, parametrised by IN_W/OUT_W and reusable elsewhere.
- The top level contains the skid-buffer control and registers.

## Test plan
- Modes with out_ready=1, default widths:
  - imm=0x8001, mode 0 → 0xFFFF8001;
  - mode 1 → 0x00008001;
  - mode 2 → 0x80010000;
  - mode 3 → 0xFFFE0004, err=0.
- BTGT wrap: pc4=0x00000010, imm=0xFFFC (−4), mode 4 → 0x00000000. Also pc4=0xFFFFFFF0, imm=0x0008 → 0x00000010.
- Reserved modes: mode 5/6/7 with imm=0x1234 → out_data=0, out_err=1. The next mode-0 beat returns err=0.
- Backpressure:
  - out_ready=0 and send beats A, B → state FULL, in_ready=0 next cycle, A held stable;
  - raise out_ready → A, then B delivered in order;
  - continuous traffic → no loss.
- Streaming: 100 random beats with out_ready toggled randomly → output sequence equals the reference-model sequence, with a maximum of 2 beats in flight.
- Reset mid-stream: rst asserted for 1 cycle while FULL → out_valid=0, out_data=0, in_ready=1 the following cycle, and buffered beats are never emitted.
- Parametric: IN_W=12, OUT_W=16, imm=0x800, mode 0 → 0xF800; mode 2 → 0x8000.
